// File: rtl/hazard_track_pipe.sv
// ============================================================================
// hazard_track_pipe : in-flight hazard tracker (dst/src/T_new per stage) with
//                     Decode stall request and forwarding-select generation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_track_pipe #(
    parameter  int STAGES = 3,
    parameter  int AW     = 5,
    parameter  int TW     = 2,
    localparam int SW     = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 ext_stall,
    input  logic                 d_valid,
    input  logic [AW-1:0]        d_rs,
    input  logic [AW-1:0]        d_rt,
    input  logic [TW-1:0]        d_rs_tuse,
    input  logic [TW-1:0]        d_rt_tuse,
    input  logic [AW-1:0]        d_dst,
    input  logic [TW-1:0]        d_tnew,
    output logic                 stall,
    output logic [SW-1:0]        fwd_rs_sel,
    output logic [SW-1:0]        fwd_rt_sel,
    output logic [STAGES*AW-1:0] stg_dst,
    output logic [STAGES*AW-1:0] stg_rs,
    output logic [STAGES*AW-1:0] stg_rt,
    output logic [STAGES*TW-1:0] stg_tnew
);

    logic [AW-1:0] r_dst  [STAGES];
    logic [AW-1:0] r_rs   [STAGES];
    logic [AW-1:0] r_rt   [STAGES];
    logic [TW-1:0] r_tnew [STAGES];

    logic          w_bubble;
    logic [SW-1:0] w_rs_pos;
    logic [SW-1:0] w_rt_pos;
    logic [TW-1:0] w_rs_ptnew;
    logic [TW-1:0] w_rt_ptnew;
    logic          w_rs_chk;
    logic          w_rt_chk;
    logic          w_rs_stall;
    logic          w_rt_stall;

    assign w_bubble = stall | ext_stall | ~d_valid;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int k = 0; k < STAGES; k++) begin
                r_dst[k]  <= '0;
                r_rs[k]   <= '0;
                r_rt[k]   <= '0;
                r_tnew[k] <= '0;
            end
        end else begin
            for (int k = 1; k < STAGES; k++) begin
                r_dst[k]  <= r_dst[k-1];
                r_rs[k]   <= r_rs[k-1];
                r_rt[k]   <= r_rt[k-1];
                r_tnew[k] <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
            end
            if (w_bubble) begin
                r_dst[0]  <= '0;
                r_rs[0]   <= '0;
                r_rt[0]   <= '0;
                r_tnew[0] <= '0;
            end else begin
                r_dst[0]  <= d_dst;
                r_rs[0]   <= d_rs;
                r_rt[0]   <= d_rt;
                r_tnew[0] <= d_tnew;
            end
        end
    end

    // Scan oldest to youngest so the youngest matching producer is what remains.
    always_comb begin
        w_rs_pos   = '0;
        w_rt_pos   = '0;
        w_rs_ptnew = '0;
        w_rt_ptnew = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (r_dst[k] != '0 && r_dst[k] == d_rs) begin
                w_rs_pos   = SW'(k + 1);
                w_rs_ptnew = r_tnew[k];
            end
            if (r_dst[k] != '0 && r_dst[k] == d_rt) begin
                w_rt_pos   = SW'(k + 1);
                w_rt_ptnew = r_tnew[k];
            end
        end
    end

    assign w_rs_chk   = d_valid && (d_rs != '0) && (w_rs_pos != '0);
    assign w_rt_chk   = d_valid && (d_rt != '0) && (w_rt_pos != '0);
    assign w_rs_stall = w_rs_chk && (w_rs_ptnew > d_rs_tuse);
    assign w_rt_stall = w_rt_chk && (w_rt_ptnew > d_rt_tuse);

    assign stall      = (w_rs_stall | w_rt_stall) & ~flush;
    assign fwd_rs_sel = (w_rs_chk && w_rs_ptnew == '0) ? w_rs_pos : '0;
    assign fwd_rt_sel = (w_rt_chk && w_rt_ptnew == '0) ? w_rt_pos : '0;

    generate
        for (genvar g = 0; g < STAGES; g++) begin : g_out
            assign stg_dst[g*AW +: AW]  = r_dst[g];
            assign stg_rs[g*AW +: AW]   = r_rs[g];
            assign stg_rt[g*AW +: AW]   = r_rt[g];
            assign stg_tnew[g*TW +: TW] = r_tnew[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_hazard_track_pipe.sv
// ============================================================================
// tb_hazard_track_pipe : vector table, hand sequences and random stimulus
//                        against an instruction-history reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_track_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: default STAGES=3, TW=2
    logic        a_reset, a_flush, a_es, a_v;
    logic [4:0]  a_rs, a_rt, a_dst;
    logic [1:0]  a_rstu, a_rttu, a_tnew;
    logic        a_stall;
    logic [1:0]  a_frs, a_frt;
    logic [14:0] a_sdst, a_srs, a_srt;
    logic [5:0]  a_stn;

    hazard_track_pipe u_dut (
        .clk(clk), .reset(a_reset), .flush(a_flush), .ext_stall(a_es),
        .d_valid(a_v), .d_rs(a_rs), .d_rt(a_rt), .d_rs_tuse(a_rstu),
        .d_rt_tuse(a_rttu), .d_dst(a_dst), .d_tnew(a_tnew),
        .stall(a_stall), .fwd_rs_sel(a_frs), .fwd_rt_sel(a_frt),
        .stg_dst(a_sdst), .stg_rs(a_srs), .stg_rt(a_srt), .stg_tnew(a_stn)
    );

    // Instance B: STAGES=5, TW=3
    logic        b_reset, b_flush, b_es, b_v;
    logic [4:0]  b_rs, b_rt, b_dst;
    logic [2:0]  b_rstu, b_rttu, b_tnew;
    logic        b_stall;
    logic [2:0]  b_frs, b_frt;
    logic [24:0] b_sdst, b_srs, b_srt;
    logic [14:0] b_stn;

    hazard_track_pipe #(.STAGES(5), .AW(5), .TW(3)) u_dut5 (
        .clk(clk), .reset(b_reset), .flush(b_flush), .ext_stall(b_es),
        .d_valid(b_v), .d_rs(b_rs), .d_rt(b_rt), .d_rs_tuse(b_rstu),
        .d_rt_tuse(b_rttu), .d_dst(b_dst), .d_tnew(b_tnew),
        .stall(b_stall), .fwd_rs_sel(b_frs), .fwd_rt_sel(b_frt),
        .stg_dst(b_sdst), .stg_rs(b_srs), .stg_rt(b_srt), .stg_tnew(b_stn)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: history of what entered stage 0 at each of the last
    // three edges, with the T_new it carried on entry; age gives the decay.
    typedef struct packed {
        logic [4:0] dst;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [1:0] tnew0;
    } ent_t;

    ent_t hist [3];

    function automatic int age_tnew(input int k);
        return (int'(hist[k].tnew0) > k) ? int'(hist[k].tnew0) - k : 0;
    endfunction

    function automatic void hz(input logic [4:0] src, input logic [1:0] tuse,
                               output bit st, output logic [1:0] sel);
        bit found = 0;
        st  = 0;
        sel = 2'd0;
        if (a_v && src != 5'd0) begin
            for (int k = 0; k < 3; k++) begin
                if (!found && hist[k].dst == src) begin
                    found = 1;
                    st    = age_tnew(k) > int'(tuse);
                    sel   = (age_tnew(k) == 0) ? 2'(k + 1) : 2'd0;
                end
            end
        end
    endfunction

    function automatic void mdl(output bit st, output logic [1:0] srs, output logic [1:0] srt);
        bit s1, s2;
        hz(a_rs, a_rstu, s1, srs);
        hz(a_rt, a_rttu, s2, srt);
        st = (s1 | s2) & ~a_flush;
    endfunction

    always @(posedge clk) begin : model_upd
        bit         ms;
        logic [1:0] xs, ys;
        mdl(ms, xs, ys);
        if (a_reset || a_flush) begin
            for (int k = 0; k < 3; k++) hist[k] <= '0;
        end else begin
            hist[2] <= hist[1];
            hist[1] <= hist[0];
            hist[0] <= (ms || a_es || !a_v) ? '0 : {a_dst, a_rs, a_rt, a_tnew};
        end
    end

    task automatic chk_a(input string tag);
        bit         ms;
        logic [1:0] xs, ys;
        mdl(ms, xs, ys);
        chk({tag, ".stall"}, 32'(a_stall), 32'(ms));
        chk({tag, ".fwd_rs"}, 32'(a_frs), 32'(xs));
        chk({tag, ".fwd_rt"}, 32'(a_frt), 32'(ys));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s.dst%0d", tag, k), 32'(a_sdst[k*5 +: 5]), 32'(hist[k].dst));
            chk($sformatf("%s.rs%0d", tag, k), 32'(a_srs[k*5 +: 5]), 32'(hist[k].rs));
            chk($sformatf("%s.rt%0d", tag, k), 32'(a_srt[k*5 +: 5]), 32'(hist[k].rt));
            chk($sformatf("%s.tnew%0d", tag, k), 32'(a_stn[k*2 +: 2]), 32'(age_tnew(k)));
        end
    endtask

    task automatic drive_a(input bit fl, input bit es, input bit v,
                           input logic [4:0] dst, input logic [1:0] tnew,
                           input logic [4:0] rs, input logic [1:0] rstu,
                           input logic [4:0] rt, input logic [1:0] rttu);
        a_flush = fl; a_es = es; a_v = v; a_dst = dst; a_tnew = tnew;
        a_rs = rs; a_rstu = rstu; a_rt = rt; a_rttu = rttu;
    endtask

    typedef struct {
        bit         fl, es, v;
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [1:0] rstu;
        logic [4:0] rt;
        logic [1:0] rttu;
        bit         e_stall;
        logic [1:0] e_rs, e_rt;
    } vec_t;

    vec_t tbl [22];

    initial begin
        //        fl es v  dst tn  rs tu  rt tu  stall rs rt
        tbl[0]  = '{0, 0, 1,  8, 2,  0, 0,  0, 0,  0, 0, 0};  // load
        tbl[1]  = '{0, 0, 1, 10, 1,  8, 0,  0, 0,  1, 0, 0};  // load-use
        tbl[2]  = '{0, 0, 1, 10, 1,  8, 0,  0, 0,  1, 0, 0};
        tbl[3]  = '{0, 0, 1, 10, 1,  8, 0,  0, 0,  0, 3, 0};
        tbl[4]  = '{0, 0, 1,  9, 1,  0, 0,  0, 0,  0, 0, 0};  // ALU producer
        tbl[5]  = '{0, 0, 1,  0, 0,  0, 0,  9, 1,  0, 0, 0};
        tbl[6]  = '{0, 0, 1,  0, 0,  0, 0,  9, 0,  0, 0, 2};
        tbl[7]  = '{0, 0, 1,  5, 0,  0, 0,  0, 0,  0, 0, 0};  // youngest wins
        tbl[8]  = '{0, 0, 1,  0, 0,  0, 0,  0, 0,  0, 0, 0};
        tbl[9]  = '{0, 0, 1,  5, 1,  0, 0,  0, 0,  0, 0, 0};
        tbl[10] = '{0, 0, 1,  0, 0,  5, 0,  0, 0,  1, 0, 0};
        tbl[11] = '{0, 0, 1,  0, 0,  5, 0,  0, 0,  0, 2, 0};
        tbl[12] = '{0, 0, 1,  0, 2,  0, 0,  0, 0,  0, 0, 0};  // $zero
        tbl[13] = '{0, 0, 1,  0, 0,  0, 0,  0, 0,  0, 0, 0};
        tbl[14] = '{0, 0, 1,  7, 3,  0, 0,  0, 0,  0, 0, 0};
        tbl[15] = '{0, 0, 0,  0, 0,  7, 0,  0, 0,  0, 0, 0};  // invalid D
        tbl[16] = '{0, 0, 1,  0, 0,  7, 0,  7, 3,  1, 0, 0};
        tbl[17] = '{0, 0, 1,  0, 0,  7, 0,  7, 3,  1, 0, 0};
        tbl[18] = '{0, 0, 1,  0, 0,  7, 0,  7, 3,  0, 0, 0};  // drained
        tbl[19] = '{0, 0, 1,  3, 2,  0, 0,  0, 0,  0, 0, 0};
        tbl[20] = '{1, 0, 1,  0, 0,  3, 0,  0, 0,  0, 0, 0};  // flush masks
        tbl[21] = '{0, 0, 1,  0, 0,  3, 0,  0, 0,  0, 0, 0};

        a_reset = 1'b1; b_reset = 1'b1;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        b_flush = 0; b_es = 0; b_v = 0; b_dst = 0; b_tnew = 0;
        b_rs = 0; b_rstu = 0; b_rt = 0; b_rttu = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_reset = 1'b0; b_reset = 1'b0;

        // Reset state with a hazard-looking D instruction
        drive_a(0, 0, 1, 3, 3, 4, 0, 6, 0);
        #1;
        chk("rst.stg_dst", 32'(a_sdst), 32'd0);
        chk("rst.stg_tnew", 32'(a_stn), 32'd0);
        chk("rst.stall", 32'(a_stall), 32'd0);
        chk("rst.fwd_rs", 32'(a_frs), 32'd0);
        chk("rst.b_stg_dst", 32'(b_sdst), 32'd0);
        chk("rst.b_stg_tnew", 32'(b_stn), 32'd0);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive_a(tbl[i].fl, tbl[i].es, tbl[i].v, tbl[i].dst, tbl[i].tnew,
                    tbl[i].rs, tbl[i].rstu, tbl[i].rt, tbl[i].rttu);
            #1;
            chk($sformatf("tbl%0d.stall", i), 32'(a_stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d.fwd_rs", i), 32'(a_frs), 32'(tbl[i].e_rs));
            chk($sformatf("tbl%0d.fwd_rt", i), 32'(a_frt), 32'(tbl[i].e_rt));
            chk_a($sformatf("tbl%0d", i));
        end

        // ext_stall for three cycles drains three older entries
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            drive_a(0, 0, 1, 5'(i), 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_a(0, 1, 1, 5'd4, 1, 0, 0, 0, 0);
            #1;
            chk($sformatf("es%0d.stall", i), 32'(a_stall), 32'd0);
            chk($sformatf("es%0d.dst", i), 32'(a_sdst),
                (i == 0) ? {17'd0, 5'd1, 5'd2, 5'd3} :
                (i == 1) ? {17'd0, 5'd2, 5'd3, 5'd0} : {17'd0, 5'd3, 5'd0, 5'd0});
        end
        @(negedge clk);
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("es_end.dst", 32'(a_sdst), 32'd0);

        // Randomized traffic against the history model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            a_reset = ($urandom_range(0, 99) < 2);
            drive_a($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)),
                    2'($urandom), 5'($urandom_range(0, 7)), 2'($urandom),
                    5'($urandom_range(0, 7)), 2'($urandom));
            #1;
            chk_a($sformatf("rnd%0d", i));
        end
        @(negedge clk);
        a_reset = 1'b0;
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // STAGES=5 sweep: four stall cycles then forward from stage 4
        b_v = 1; b_dst = 5'd8; b_tnew = 3'd4;
        @(negedge clk);
        b_dst = 5'd11; b_tnew = 3'd0; b_rs = 5'd8; b_rstu = 3'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("p5.stall%0d", i), 32'(b_stall), 32'd1);
            chk($sformatf("p5.tnew%0d", i), 32'(b_stn[i*3 +: 3]), 32'(4 - i));
            @(negedge clk);
        end
        #1;
        chk("p5.stall_end", 32'(b_stall), 32'd0);
        chk("p5.fwd_rs", 32'(b_frs), 32'd5);
        @(negedge clk);
        b_rs = 5'd0; b_dst = 5'd12; b_tnew = 3'd5;
        @(negedge clk);
        b_reset = 1'b1; b_flush = 1'b0; b_rs = 5'd12;
        #1;
        chk("p5.pre_rst_dst", 32'(b_sdst[4:0]), 32'd12);
        chk("p5.pre_rst_stall", 32'(b_stall), 32'd1);
        @(negedge clk);
        b_reset = 1'b0;
        #1;
        chk("p5.rst_dst", 32'(b_sdst), 32'd0);
        chk("p5.rst_rs", 32'(b_srs), 32'd0);
        chk("p5.rst_tnew", 32'(b_stn), 32'd0);
        chk("p5.rst_stall", 32'(b_stall), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_track_pipe.md
# hazard_track_pipe

Parametrised in-flight hazard tracker for the pipelined MIPS core. It carries destination register, T_new countdown and source registers for every instruction past Decode through `STAGES` pipeline slots (E, M, W by default). Against the Decode-stage instruction's sources and T_use it produces the stall request and the Decode-read forwarding select. Sits beside the D/E, E/M and M/W datapath registers and replaces per-stage hand-written hazard registers; adds depth/width generalisation, bubble insertion, external stall and flush.

## Interface
- `STAGES`, 3: number of tracked stages after Decode (stage 0 = E, …, STAGES-1 = W); must be ≥1.
- `AW`, 5: register address width.
- `TW`, 2: T_new / T_use width.
- `SW`: derived, $clog2(STAGES+1); forwarding-select width.

Ports (reset: reset, synchronous, active-high; clock: clk):
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high; clears all stages.
- `flush`  in  1  exception/eret flush; clears all stages next edge.
- `ext_stall`  in  1  external stall (e.g. MD unit busy); forces bubble into stage 0.
- `d_valid`  in  1  Decode holds a real instruction.
- `d_rs`, `d_rt`  in  AW each  Decode sources; 0 = unused.
- `d_rs_tuse`, `d_rt_tuse`  in  TW each  cycles until each source is needed.
- `d_dst`  in  AW  Decode destination; 0 = none.
- `d_tnew`  in  TW  T_new of the Decode instruction on entering stage 0.
- `stall`  out  1  hold PC and F/D; combinational.
- `fwd_rs_sel`, `fwd_rt_sel`  out  SW each  0 = register file, k = result of stage k-1; combinational.
- `stg_dst`, `stg_rs`, `stg_rt`  out  STAGES*AW each  per-stage fields, stage k at bits [k*AW +: AW].
- `stg_tnew`  out  STAGES*TW  per-stage T_new, stage k at [k*TW +: TW].

## Operation
- Each stage holds {dst, rs, rt, tnew}. A bubble is all-zero.
- Per edge, priority order:
  - reset: all stages zero.
  - flush: all stages zero.
  - otherwise, stage k+1 ← stage k with tnew' = (tnew==0) ? 0 : tnew-1, saturating.
  - Stage 0 ← bubble if `stall | ext_stall | !d_valid`; otherwise ← {d_dst, d_rs, d_rt, d_tnew}.
  - Contents of stage STAGES-1 are discarded.
- Hazard check, evaluated independently for src ∈ {d_rs, d_rt} with its tuse:
  - Skip if src==0 or !d_valid.
  - Match = lowest k with stg_dst[k]==src (dst 0 never matches); the youngest producer wins.
  - Stall term: match exists and stg_tnew[k] > tuse.
  - fwd_sel = k+1 if the match exists and stg_tnew[k]==0; otherwise 0. This covers a pending but non-stalling producer, whose forwarding is resolved in later stages.
- `stall` = OR of both stall terms, masked to 0 while `flush`=1. `ext_stall` does not drive `stall`.
- Width rules: tnew/tuse compared unsigned in TW bits. All outputs are plain functions of the registers and the D inputs.

## Timing
- Reset value of every registered output (stg_*) is 0. With all stages zero after reset, `stall`=0 and fwd_*_sel=0 for any D input.
- Latency: a D instruction accepted at edge n appears in stage k after edge n+k. Its tnew at stage k is max(d_tnew-k, 0).
- `stall`/fwd react in the same cycle as D inputs or stage contents change; no registered delay.
- Stall and ext_stall in the same cycle: single bubble, identical to either alone.
- Flush and stall together: flush wins; stages cleared; `stall`=0.
- Reset mid-operation: next edge all zero regardless of flush/stall.
- Producer and consumer with dst==src==0: no hazard, sel 0.

## Test plan
- Load-use (STAGES=3): load with d_dst=8, d_tnew=2 accepted; next D has d_rs=8, tuse=0. Required: stall=1 for exactly 2 cycles with bubbles in stage 0, then stall=0, fwd_rs_sel=3, stg_tnew[2]=0.
- ALU back-to-back: d_dst=9, d_tnew=1, then consumer d_rt=9, tuse=1. Required: stall=0, fwd_rt_sel=0. Next cycle, stage 1 holds dst 9 with tnew 0.
- Youngest wins: $5 written at stage 2 (tnew 0) and at stage 0 (tnew 1); consumer rs=5, tuse=0. Required: stall=1 (the stage 0 producer governs), not fwd_rs_sel=3.
- $zero: producer d_dst=0, d_tnew=2; consumer rs=0, tuse=0. Required: stall=0, fwd_rs_sel=0.
- ext_stall=1 for 3 cycles with a valid D instruction. Required: 3 bubbles enter stage 0 and the older entries drain. flush=1 with stall pending: stall=0 that cycle, and all stg_* are 0 next cycle.
- Param sweep STAGES=5, TW=3, d_tnew=4, consumer tuse=0. Required: 4 stall cycles, then fwd_rs_sel=5. Reset asserted mid-sequence clears all stg_* next edge.
